bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) converter: takes a binary value and produces four BCD digits plus a decimal-point vector.
- Sits directly upstream of the 4-digit seven-segment multiplexer. bcd3..bcd0 drive its hex3..hex0 inputs; dp_out drives its 5-bit dp_in.
- Outputs are registered and hold the last result, so the display stays stable while a new conversion runs.

Parameters:
- W, 14, width of binary input. Legal range 4..14.
- MAXV, 9999, largest convertible value. Any input above it is an overflow.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request conversion. Sampled only in IDLE.
- bin  in  W  binary value. Latched on accepted start.
- dp_en  in  1  enable decimal point. Latched on accepted start.
- dp_pos  in  2  digit index (0..3) carrying the decimal point. Latched on accepted start.
- ready  out  1  high while in IDLE
- done_tick  out  1  one-cycle pulse when a new result is on the outputs
- overflow  out  1  registered. 1 if the last accepted bin exceeded MAXV.
- bcd3, bcd2, bcd1, bcd0  out  4 each  result digits, bcd3 = thousands
- dp_out  out  5  active-low decimal points. Bit 4 is always 1.

Behaviour:
- Reset (asynchronous, active-high; any state, including mid-conversion):
  - state=IDLE.
  - bcd3..bcd0=0, overflow=0, dp_out=5'b11111, done_tick=0, ready=1.
  - Shift, bin and iteration registers are cleared.
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch bin into the shift register, clear the working BCD registers, load n=W, latch dp_en/dp_pos.
  - If bin>MAXV, go to DONE with the overflow path selected. Otherwise go to OP.
  - With start=0, stay in IDLE.
- OP, one iteration per cycle:
  - Each working digit ≥5 gets +3 (4-bit arithmetic, no carry between digits).
  - Then the concatenation {bcd3w,bcd2w,bcd1w,bcd0w,binw} shifts left by 1, and n decrements.
  - When n==1 at the clock edge, this is the final shift. Go to DONE, and on the same edge load the output registers bcd3..bcd0 from the post-shift working values.
- DONE (exactly one cycle):
  - done_tick=1. Next state is IDLE.
  - On the overflow path, outputs load 4'hE in all four digits ("EEEE") and overflow=1. Otherwise overflow=0.
  - dp_out is updated on entry to DONE: bit dp_pos=0 if dp_en=1, all other bits 1.
- Latency: start accepted at edge k → done_tick high in cycle k+W+1, with outputs already valid in that cycle. Overflow path: done_tick in cycle k+1.
- Back-to-back operation: earliest next accept is the cycle after DONE. Throughput is one conversion per W+2 cycles.
- start while in OP or DONE is ignored. It is not queued.
- Changing bin, dp_en or dp_pos after acceptance has no effect on the current conversion.
- Output registers change only on entry to DONE or on reset. They never show partial results.
- bin is zero-extended internally to 14 bits. For W<14, overflow is unreachable but its logic is still present.

Decomposition:
- Shared package:
  - state encoding constants IDLE/OP/DONE
  - BCD_DIGITS=4
  - OVF_DIGIT=4'hE
  - DP_OFF=1'b1 (active-low decimal-point convention, shared with the display mux)
- One natural sub-module: bcd_adj3 (combinational: 4-bit in, +3 if ≥5). Instantiated four times.
- Everything else stays in one module.

Test Plan:
- Reset asserted mid-conversion of 1234 (cycle 5 of OP) → all outputs immediately return to reset values. ready=1 on the next edge. No done_tick.
- bin=1234, dp_en=1, dp_pos=2, start pulse → done_tick exactly W+1=15 cycles after accept. bcd3..0=1,2,3,4. dp_out=5'b11011. overflow=0.
- bin=0, then separately bin=9999 (dp_en=0) → results 0,0,0,0 and 9,9,9,9. dp_out=5'b11111 in both cases.
- bin=10000 → done_tick 1 cycle after accept. Digits E,E,E,E. overflow=1. A following bin=42 gives 0,0,4,2 with overflow=0.
- start held high continuously with bin changing every cycle → each conversion uses the value latched at its accept edge. Accept edges are spaced W+2 cycles apart. Between done_ticks the outputs stay stable.
- Random bin in 0..9999, 1000 iterations → digits match a reference decimal split. Each done_tick lasts exactly 1 cycle. ready is low from accept through DONE.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_pkg
// Brief    : Shared types and constants for the sequential binary-to-BCD path
// Revision : 1.0 - initial release
// ============================================================================
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_DIGITS = 4;
  localparam int         BIN_W      = 14;
  localparam logic [3:0] OVF_DIGIT  = 4'hE;
  // Decimal points are active-low, matching the display multiplexer.
  localparam logic       DP_OFF     = 1'b1;

  function automatic logic [4:0] dp_vec(input logic en, input logic [1:0] pos);
    logic [4:0] v;
    v = {5{DP_OFF}};
    if (en) v[{1'b0, pos}] = ~DP_OFF;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_adj3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_adj3
// Brief    : Double-dabble digit correction, adds 3 to any digit of 5 or more
// Revision : 1.0 - initial release
// ============================================================================
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential shift-and-add-3 converter, 4 BCD digits + decimal point
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int W    = 14,
  parameter int MAXV = 9999
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  input  logic         dp_en,
  input  logic [1:0]   dp_pos,
  output logic         ready,
  output logic         done_tick,
  output logic         overflow,
  output logic [3:0]   bcd3,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic [4:0]   dp_out
);

  localparam int               ALIGN  = BIN_W - W;
  localparam logic [BIN_W-1:0] MAXV_L = BIN_W'(MAXV);
  localparam logic [3:0]       N_INIT = 4'(W);

  state_t                         state_q, state_d;
  logic [BIN_W-1:0]               bin_q, bin_d;
  logic [BCD_DIGITS-1:0][3:0]     work_q, work_d;
  logic [3:0]                     n_q, n_d;
  logic                           dp_en_q, dp_en_d;
  logic [1:0]                     dp_pos_q, dp_pos_d;
  logic [BCD_DIGITS-1:0][3:0]     bcd_q, bcd_d;
  logic                           overflow_q, overflow_d;
  logic [4:0]                     dp_out_q, dp_out_d;

  logic [BIN_W-1:0]               bin_ext;
  logic [BIN_W-1:0]               bin_align;
  logic [BCD_DIGITS-1:0][3:0]     adj;
  logic [BCD_DIGITS-1:0][3:0]     work_next;
  logic [BIN_W-1:0]               bin_next;
  logic [4*BCD_DIGITS+BIN_W:0]    shift_full;
  logic                           unused_shift_msb;

  assign bin_ext = BIN_W'(bin);
  // Narrow inputs are MSB-aligned so exactly W shifts bring every bit into the digits.
  assign bin_align = bin_ext << ALIGN;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (work_q[i]),
      .dout (adj[i])
    );
  end

  assign shift_full = {adj, bin_q, 1'b0};
  assign {unused_shift_msb, work_next, bin_next} = shift_full;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    n_d        = n_q;
    dp_en_d    = dp_en_q;
    dp_pos_d   = dp_pos_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    dp_out_d   = dp_out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = bin_align;
          work_d   = '0;
          n_d      = N_INIT;
          dp_en_d  = dp_en;
          dp_pos_d = dp_pos;
          if (bin_ext > MAXV_L) begin
            state_d    = DONE;
            bcd_d      = {BCD_DIGITS{OVF_DIGIT}};
            overflow_d = 1'b1;
            dp_out_d   = dp_vec(dp_en, dp_pos);
          end else begin
            state_d = OP;
          end
        end
      end
      OP: begin
        work_d = work_next;
        bin_d  = bin_next;
        n_d    = n_q - 4'd1;
        if (n_q == 4'd1) begin
          state_d    = DONE;
          bcd_d      = work_next;
          overflow_d = 1'b0;
          dp_out_d   = dp_vec(dp_en_q, dp_pos_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      n_q        <= '0;
      dp_en_q    <= 1'b0;
      dp_pos_q   <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      dp_out_q   <= {5{DP_OFF}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      n_q        <= n_d;
      dp_en_q    <= dp_en_d;
      dp_pos_q   <= dp_pos_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      dp_out_q   <= dp_out_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign overflow  = overflow_q;
  assign bcd3      = bcd_q[3];
  assign bcd2      = bcd_q[2];
  assign bcd1      = bcd_q[1];
  assign bcd0      = bcd_q[0];
  assign dp_out    = dp_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Scoreboard bench for bin2bcd_seq against a decimal reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int W    = 14;
  localparam int MAXV = 9999;

  typedef struct {
    logic [15:0] digits;
    logic        ovf;
    logic [4:0]  dp;
    int          cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] bin = '0;
  logic         dp_en = 1'b0;
  logic [1:0]   dp_pos = '0;
  logic         ready, done_tick, overflow;
  logic [3:0]   bcd3, bcd2, bcd1, bcd0;
  logic [4:0]   dp_out;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rst_events = 0;
  exp_t sb[$];

  bin2bcd_seq #(.W(W), .MAXV(MAXV)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .dp_en     (dp_en),
    .dp_pos    (dp_pos),
    .ready     (ready),
    .done_tick (done_tick),
    .overflow  (overflow),
    .bcd3      (bcd3),
    .bcd2      (bcd2),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .dp_out    (dp_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain decimal split of the value, accept edge plus W shifts.
  function automatic exp_t model(input int v, input bit en, input int pos, input int k);
    exp_t e;
    if (v > MAXV) begin
      e.digits = 16'hEEEE;
      e.ovf    = 1'b1;
      e.cyc    = k;
    end else begin
      e.digits = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf    = 1'b0;
      e.cyc    = k + W;
    end
    e.dp = 5'b11111;
    if (en) e.dp[3'(pos)] = 1'b0;
    return e;
  endfunction

  task automatic scramble();
    bin    = W'($urandom);
    dp_en  = 1'($urandom);
    dp_pos = 2'($urandom);
  endtask

  task automatic run(input int v, input bit en, input int pos, input int gap, input bit hold);
    int k;
    int busy;
    @(negedge clk);
    check("ready_idle", {31'd0, ready}, 32'd1);
    start  = 1'b1;
    bin    = W'(v);
    dp_en  = en;
    dp_pos = 2'(pos);
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back(model(v, en, pos, k));
    check("ready_busy", {31'd0, ready}, 32'd0);
    start = hold;
    scramble();
    busy = (v > MAXV) ? 1 : W + 1;
    repeat (busy + gap) begin
      @(negedge clk);
      scramble();
    end
  endtask

  // Monitor: pops the scoreboard on each done_tick, otherwise outputs must hold.
  logic [25:0] prev_out;
  logic        prev_done;
  int          seen_rst;
  initial begin
    seen_rst  = 0;
    prev_out  = '0;
    prev_done = 1'b0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset || seen_rst != rst_events) begin
      seen_rst = rst_events;
    end else if (done_tick) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, {16'd0, e.digits});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("dp_out", {27'd0, dp_out}, {27'd0, e.dp});
        check("latency", cyc, e.cyc);
        check("ready_in_done", {31'd0, ready}, 32'd0);
      end
    end else begin
      check("hold", {6'd0, bcd3, bcd2, bcd1, bcd0, overflow, dp_out}, {6'd0, prev_out});
    end
    prev_out  = {bcd3, bcd2, bcd1, bcd0, overflow, dp_out};
    prev_done = done_tick;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    check("rst_dp", {27'd0, dp_out}, 32'h1F);
    check("rst_flags", {29'd0, overflow, done_tick, ready}, 32'd1);
    reset = 1'b0;

    run(1234, 1'b1, 2, 2, 1'b0);
    run(0, 1'b0, 0, 1, 1'b0);
    run(9999, 1'b0, 3, 0, 1'b0);
    run(10000, 1'b1, 0, 1, 1'b0);
    run(42, 1'b1, 3, 2, 1'b0);

    // Abort a conversion of 1234 five cycles into OP.
    @(negedge clk);
    check("ready_idle", {31'd0, ready}, 32'd1);
    start = 1'b1; bin = W'(1234); dp_en = 1'b1; dp_pos = 2'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_events++;
    reset = 1'b1;
    #1;
    check("arst_digits", {16'd0, bcd3, bcd2, bcd1, bcd0}, 32'd0);
    check("arst_dp", {27'd0, dp_out}, 32'h1F);
    check("arst_flags", {29'd0, overflow, done_tick, ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, ready}, 32'd1);
    repeat (W + 3) @(negedge clk);

    // start held high with bin changing every cycle
    for (int i = 0; i < 8; i++)
      run((i == 3) ? 12000 : int'($urandom_range(16383)), 1'($urandom), int'($urandom_range(3)), 0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 1000; i++)
      run(int'($urandom_range(9999)), 1'($urandom), int'($urandom_range(3)), int'($urandom_range(2)), 1'b0);

    repeat (W + 5) @(negedge clk);
    check("drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
